// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

   // Converter control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Iteration counter width: ceil(log2(32)), enough for WIDTH-1 at the largest legal WIDTH.
   localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/bin_bcd_seq_if.sv
// Request/result bundle for bin_bcd_seq.
interface bin_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  sign_out;
   logic                  ovf;

   // Requester side: issues start/operand, observes status and results.
   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, sign_out, ovf
   );

   // Converter side.
   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, sign_out, ovf
   );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   // Correct the digit before it is doubled by the next shift.
   always_comb begin
      dout = din;
      if (din >= 4'd5) dout = din + 4'd3;
   end
endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with optional two's-complement input and saturating overflow.
module bin_bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   bin_bcd_seq_if.slave   bus
);
   localparam int unsigned BW = 4 * DIGITS;
   localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  sr;
   logic [BW-1:0]     dig;
   logic              ovf_flag;
   logic              neg;

   logic [BW-1:0]     dig_adj;
   logic [BW-1:0]     dig_nxt;
   logic [WIDTH-1:0]  sr_nxt;
   logic              carry_out;
   logic              ovf_nxt;
   logic              neg_in;
   logic [WIDTH-1:0]  mag;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (dig[4*i +: 4]),
         .dout (dig_adj[4*i +: 4])
      );
   end

   // Operand magnitude/sign and the next double-dabble step.
   always_comb begin
      neg_in = 1'b0;
      mag    = bus.bin_in;
      if ((SIGNED != 0) && bus.bin_in[WIDTH-1]) begin
         neg_in = 1'b1;
         mag    = ~bus.bin_in + WIDTH'(1);
      end
      {carry_out, dig_nxt, sr_nxt} = {dig_adj, sr, 1'b0};
      ovf_nxt = ovf_flag | carry_out;
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         sr           <= '0;
         dig          <= '0;
         ovf_flag     <= 1'b0;
         neg          <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd_out  <= '0;
         bus.sign_out <= 1'b0;
         bus.ovf      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state    <= SHIFT;
                  bus.busy <= 1'b1;
                  sr       <= mag;
                  dig      <= '0;
                  cnt      <= CNT_W'(WIDTH - 1);
                  ovf_flag <= 1'b0;
                  neg      <= neg_in;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            SHIFT: begin
               sr       <= sr_nxt;
               dig      <= dig_nxt;
               ovf_flag <= ovf_nxt;
               if (cnt == '0) begin
                  state        <= DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.bcd_out  <= ovf_nxt ? ALL9 : dig_nxt;
                  bus.sign_out <= neg;
                  bus.ovf      <= ovf_nxt;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/bin_bcd_seq.md
BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have parameter SIGNED, default 1: 1 means bin_in is two's complement, 0 means unsigned.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: request a conversion of bin_in; sampled on the rising edge.
REQ-007 SHALL have port bin_in, input, WIDTH: operand, sampled only on the edge that accepts start.
REQ-008 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high when results are valid.
REQ-010 SHALL have port bcd_out, output, 4*DIGITS: result digits, with digit 0 (units) in bits [3:0].
REQ-011 SHALL have port sign_out, output, 1: high when the operand was negative.
REQ-012 SHALL have port ovf, output, 1: high when the magnitude exceeds 10^DIGITS-1.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE: busy is high only in SHIFT, done is high only in DONE.
REQ-014 SHALL, on a rising edge in IDLE or DONE with start=1, go to SHIFT, then:
- load the magnitude into the shift register;
- clear the digit registers;
- set the iteration counter to WIDTH-1.
REQ-015 SHALL compute the magnitude as ~bin_in+1 when SIGNED=1 and bin_in[WIDTH-1]=1, else as bin_in; the magnitude is held in WIDTH unsigned bits, so -2^(WIDTH-1) is exact.
REQ-016 SHALL perform one double-dabble iteration per SHIFT edge, as follows:
- add 3 to every digit that is >=5;
- shift {digits, shift register} left by one.
REQ-017 SHALL, on the SHIFT edge with counter=0, move to DONE and register bcd_out, sign_out and ovf; done is therefore high in the cycle after the WIDTH-th edge following acceptance.
REQ-018 SHALL go from DONE to IDLE on the next edge unless start=1 (REQ-014), giving a back-to-back throughput of one result per WIDTH+1 cycles.
REQ-019 SHALL ignore start while in SHIFT; the in-flight operand and result are unaffected.
REQ-020 SHALL set a sticky overflow flag if any 1 is shifted out of the top digit during a conversion; the flag is cleared on start.
REQ-021 SHALL, when the overflow flag is set at completion, drive ovf=1 and saturate bcd_out to all digits 9.
REQ-022 SHALL drive sign_out=0 whenever SIGNED=0, and sign_out=0 for an input of zero.
REQ-023 SHALL hold bcd_out, sign_out and ovf stable from completion until the next completion.

Reset
REQ-024 SHALL, while rst_n=0 regardless of clk, force the following:
- state=IDLE;
- busy=0, done=0;
- bcd_out=0, sign_out=0, ovf=0;
- counter=0 and all internal registers cleared.
REQ-025 SHALL abort any conversion in progress when reset is asserted, with no done pulse afterwards; the first conversion after release needs a fresh start.

Structure
REQ-026 SHALL take the state encoding and the ceil-log2 counter-width constant from shared package bin_bcd_pkg.
REQ-027 SHALL instantiate sub-module bcd_add3 (4-bit in, 4-bit out, combinational: add 3 if >=5) DIGITS times.

Verification
REQ-028 SHALL cover, with WIDTH=8, SIGNED=1, DIGITS=3:
- bin_in=8'h7F: bcd_out=12'h127, sign_out=0, ovf=0, done 8 cycles after the accepting edge;
- bin_in=8'h80: bcd_out=12'h128, sign_out=1;
- bin_in=8'hFF: bcd_out=12'h001, sign_out=1.
REQ-029 SHALL cover, with WIDTH=8, SIGNED=0: bin_in=8'hFF gives bcd_out=12'h255 and sign_out=0; bin_in=0 gives 12'h000.
REQ-030 SHALL cover, with WIDTH=16, SIGNED=0, DIGITS=4:
- 16'h270F gives 16'h9999 with ovf=0;
- 16'h2710 gives 16'h9999 with ovf=1;
- 16'hFFFF gives ovf=1.
REQ-031 SHALL cover start pulsed in SHIFT (ignored, the first result is unchanged) and start held high in DONE (second result follows WIDTH+1 cycles after the first done).
REQ-032 SHALL cover rst_n driven low 3 cycles into a conversion: busy=0 and all outputs 0 immediately, with no done pulse.
REQ-033 SHALL cover an exhaustive sweep for WIDTH=8, in both SIGNED modes, against a reference model.
